// File: rtl/alu_mc_if.sv
// alu_mc port bundle: operand/opcode request channel plus result/flag response channel.
// Latency: none (wires only).
// Backpressure: in_ready stalls the producer, out_ready stalls alu_mc's result register.
interface alu_mc_if #(
  parameter int NBITS = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] A;
  logic [NBITS-1:0] B;
  logic [3:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [NBITS-1:0] result;
  logic             carryout;
  logic             overflow;
  logic             zero;
  logic             busy;

  // Producer/consumer side (decode + writeback stages)
  modport master (
    output in_valid, A, B, opcode, out_ready,
    input  in_ready, out_valid, result, carryout, overflow, zero, busy
  );

  // ALU side
  modport slave (
    input  in_valid, A, B, opcode, out_ready,
    output in_ready, out_valid, result, carryout, overflow, zero, busy
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle handshaked ALU (add/sub/logic/shift/compare, optional iterative MULU when ALU_MUL_EN is defined).
// Latency: 1 cycle for single-cycle ops, NBITS+1 cycles for MULU (one shift-add step per cycle).
// Backpressure: result register holds while out_valid && !out_ready; in_ready drops until it drains and while multiplying.
module alu_mc #(
  parameter int NBITS = 32
) (
  input logic     i_clk,
  input logic     i_reset,
  alu_mc_if.slave io
);
  localparam int SHW = $clog2(NBITS);

  localparam logic [3:0] OP_UADD = 4'd0;
  localparam logic [3:0] OP_SADD = 4'd1;
  localparam logic [3:0] OP_USUB = 4'd2;
  localparam logic [3:0] OP_SSUB = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SRA1 = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd11;
  localparam logic [3:0] OP_SLTU = 4'd12;

  logic [NBITS:0]   w_sum;
  logic [NBITS:0]   w_dif;
  logic [SHW-1:0]   w_sh;
  logic [NBITS-1:0] w_alu_res;
  logic             w_alu_cout;
  logic             w_alu_ovf;

  logic             w_idle;
  logic             w_in_rdy;
  logic             w_accept;
  logic             w_is_mul;

  logic             w_ld;
  logic [NBITS-1:0] w_ld_res;
  logic             w_ld_cout;
  logic             w_ld_ovf;

  logic [NBITS-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_out_vld;

  // A new op may enter in the same cycle the previous result drains.
  assign w_in_rdy = i_reset && w_idle && (!r_out_vld || io.out_ready);
  assign w_accept = io.in_valid && w_in_rdy;

  // Single-cycle datapath; reserved opcodes fall through to all-ones with clear flags.
  always_comb begin
    w_sum      = {1'b0, io.A} + {1'b0, io.B};
    w_dif      = {1'b0, io.A} - {1'b0, io.B};  // top bit is the unsigned borrow
    w_sh       = io.B[SHW-1:0];
    w_alu_res  = '1;
    w_alu_cout = 1'b0;
    w_alu_ovf  = 1'b0;
    case (io.opcode)
      OP_UADD: begin
        w_alu_res  = w_sum[NBITS-1:0];
        w_alu_cout = w_sum[NBITS];
      end
      OP_SADD: begin
        w_alu_res = w_sum[NBITS-1:0];
        w_alu_ovf = (io.A[NBITS-1] == io.B[NBITS-1]) && (w_sum[NBITS-1] != io.A[NBITS-1]);
      end
      OP_USUB: begin
        w_alu_res  = w_dif[NBITS-1:0];
        w_alu_cout = w_dif[NBITS];
      end
      OP_SSUB: begin
        w_alu_res = w_dif[NBITS-1:0];
        w_alu_ovf = (io.A[NBITS-1] != io.B[NBITS-1]) && (w_dif[NBITS-1] != io.A[NBITS-1]);
      end
      OP_AND:  w_alu_res = io.A & io.B;
      OP_OR:   w_alu_res = io.A | io.B;
      OP_XOR:  w_alu_res = io.A ^ io.B;
      OP_SRA1: w_alu_res = $signed(io.A) >>> 1;
      OP_SLL:  w_alu_res = io.A << w_sh;
      OP_SRL:  w_alu_res = io.A >> w_sh;
      OP_SRA:  w_alu_res = $signed(io.A) >>> w_sh;
      OP_SLT:  w_alu_res = {{(NBITS-1){1'b0}}, ($signed(io.A) < $signed(io.B))};
      OP_SLTU: w_alu_res = {{(NBITS-1){1'b0}}, (io.A < io.B)};
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [3:0]     OP_MULU  = 4'd13;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(NBITS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2*NBITS-1:0] r_acc;
  logic [2*NBITS-1:0] r_mcand;
  logic [2*NBITS-1:0] w_acc_nxt;
  logic [NBITS-1:0]   r_mplier;
  logic [SHW-1:0]     r_cnt;
  logic               w_mul_done;

  assign w_is_mul   = (io.opcode == OP_MULU);
  // The last shift-add step is folded into the result load, so busy covers exactly NBITS cycles.
  assign w_acc_nxt  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mul_done = (r_state == S_MUL) && (r_cnt == CNT_LAST);
  assign w_idle     = (r_state == S_IDLE);
  assign io.busy    = (r_state == S_MUL);

  // State register; reset aborts any multiply in flight.
  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state: enter MUL on an accepted MULU, leave after the final step.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_mul) w_state_nxt = S_MUL;
      S_MUL:   if (w_mul_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shift-add multiplier: multiplicand moves left, multiplier right, one bit per cycle.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (w_accept && w_is_mul) begin
      r_acc    <= '0;
      r_mcand  <= {{NBITS{1'b0}}, io.A};
      r_mplier <= io.B;
      r_cnt    <= '0;
    end else if (r_state == S_MUL) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + SHW'(1);
    end
  end
`else
  assign w_is_mul = 1'b0;
  assign w_idle   = 1'b1;
  assign io.busy  = 1'b0;
`endif

  // Select what loads into the result register this cycle.
  always_comb begin
    w_ld      = w_accept && !w_is_mul;
    w_ld_res  = w_alu_res;
    w_ld_cout = w_alu_cout;
    w_ld_ovf  = w_alu_ovf;
`ifdef ALU_MUL_EN
    if (w_mul_done) begin
      w_ld      = 1'b1;
      w_ld_res  = w_acc_nxt[NBITS-1:0];
      w_ld_cout = |w_acc_nxt[2*NBITS-1:NBITS];
      w_ld_ovf  = 1'b0;
    end
`endif
  end

  // Result register: load new result, else hold until the consumer takes it.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_result  <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_zero    <= 1'b0;
      r_out_vld <= 1'b0;
    end else if (w_ld) begin
      r_result  <= w_ld_res;
      r_cout    <= w_ld_cout;
      r_ovf     <= w_ld_ovf;
      r_zero    <= (w_ld_res == '0);
      r_out_vld <= 1'b1;
    end else if (io.out_ready) begin
      r_out_vld <= 1'b0;
    end
  end

  assign io.in_ready  = w_in_rdy;
  assign io.out_valid = r_out_vld;
  assign io.result    = r_result;
  assign io.carryout  = r_cout;
  assign io.overflow  = r_ovf;
  assign io.zero      = r_zero;
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: vector table for single-cycle ops, hand sequences for stall/reset/multiply.
// Multiply sequences are built only when ALU_MUL_EN is defined; otherwise opcode 13 is checked as reserved.
module tb_alu_mc;
  localparam int N = 32;

  typedef struct packed {
    logic [3:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } vec_t;

  localparam int NV = 19;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t vt [NV];

  alu_mc_if #(.NBITS(N)) bus ();

  alu_mc #(.NBITS(N)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .io      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op and hold it until the handshake completes (bounded).
  task automatic send(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    bit rdy;
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.A        = a;
    bus.B        = b;
    for (int i = 0; i < 60 && !done; i++) begin
      #1;
      rdy = bus.in_ready;
      tick();
      done = rdy;
    end
    bus.in_valid = 1'b0;
    check($sformatf("send op%0d accepted", op), 64'(done), 64'd1);
  endtask

`ifdef ALU_MUL_EN
  task automatic mul_check(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] res, input logic c, input logic z);
    int k;
    int nb;
    send(4'd13, a, b);
    k  = 0;
    nb = 0;
    while (!bus.out_valid && k < 100) begin
      if (bus.busy) nb++;
      tick();
      k++;
    end
    check({name, " latency"}, 64'(k + 1), 64'(N + 1));
    check({name, " busy cycles"}, 64'(nb), 64'(N));
    check({name, " vld/res/c/v/z"},
          64'({bus.out_valid, bus.result, bus.carryout, bus.overflow, bus.zero}),
          64'({1'b1, res, c, 1'b0, z}));
    check({name, " busy low at result"}, 64'(bus.busy), 64'd0);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    //          op     a             b             res           c     v     z
    vt[0]  = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[1]  = '{4'd0,  32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{4'd1,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{4'd1,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vt[4]  = '{4'd3,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{4'd2,  32'h00000001, 32'h00000002, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{4'd2,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vt[7]  = '{4'd4,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{4'd5,  32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{4'd6,  32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, 1'b0, 1'b0};
    vt[10] = '{4'd7,  32'h80000002, 32'h00000000, 32'hC0000001, 1'b0, 1'b0, 1'b0};
    vt[11] = '{4'd8,  32'h00000001, 32'h00000024, 32'h00000010, 1'b0, 1'b0, 1'b0};
    vt[12] = '{4'd9,  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vt[13] = '{4'd10, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0, 1'b0};
    vt[14] = '{4'd11, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vt[15] = '{4'd12, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vt[16] = '{4'd15, 32'h12345678, 32'h00000003, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vt[17] = '{4'd14, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vt[18] = '{4'd3,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b0};

    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.opcode    = 4'd0;
    bus.out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("reset in_ready", 64'(bus.in_ready), 64'd0);
    check("reset vld/res/c/v/z/busy",
          64'({bus.out_valid, bus.result, bus.carryout, bus.overflow, bus.zero, bus.busy}), 64'd0);
    rst_n = 1'b1;
    #1;
    check("in_ready after reset", 64'(bus.in_ready), 64'd1);

    // Single-cycle ops, back to back with the consumer always ready
    for (int i = 0; i < NV; i++) begin
      send(vt[i].op, vt[i].a, vt[i].b);
      check($sformatf("vec%0d vld/res/c/v/z", i),
            64'({bus.out_valid, bus.result, bus.carryout, bus.overflow, bus.zero}),
            64'({1'b1, vt[i].res, vt[i].c, vt[i].v, vt[i].z}));
      check($sformatf("vec%0d busy", i), 64'(bus.busy), 64'd0);
    end
    tick();
    check("drain after vectors", 64'(bus.out_valid), 64'd0);

    // Stalled consumer: first result held, second op waits, both leave in order
    bus.out_ready = 1'b0;
    send(4'd4, 32'h0000F0F0, 32'h0000FF00);
    check("stall first result", 64'({bus.out_valid, bus.result}), 64'({1'b1, 32'h0000F000}));
    bus.in_valid = 1'b1;
    bus.opcode   = 4'd5;
    bus.A        = 32'h1;
    bus.B        = 32'h2;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall in_ready %0d", k), 64'(bus.in_ready), 64'd0);
      tick();
      check($sformatf("stall hold %0d", k), 64'({bus.out_valid, bus.result}), 64'({1'b1, 32'h0000F000}));
    end
    bus.out_ready = 1'b1;
    #1;
    check("stall in_ready on drain", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    check("stall second result", 64'({bus.out_valid, bus.result}), 64'({1'b1, 32'h00000003}));
    tick();
    check("stall drained", 64'(bus.out_valid), 64'd0);

    // Reset while a result is held clears it
    bus.out_ready = 1'b0;
    send(4'd6, 32'h5, 32'h3);
    check("held xor", 64'({bus.out_valid, bus.result}), 64'({1'b1, 32'h00000006}));
    rst_n = 1'b0;
    #1;
    check("in_ready in reset", 64'(bus.in_ready), 64'd0);
    tick();
    check("reset clears held", 64'({bus.out_valid, bus.result, bus.zero}), 64'd0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();

`ifdef ALU_MUL_EN
    mul_check("mul 7*6", 32'd7, 32'd6, 32'd42, 1'b0, 1'b0);
    mul_check("mul 2^16*2^16", 32'h00010000, 32'h00010000, 32'h0, 1'b1, 1'b1);
    mul_check("mul max*max", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 1'b1, 1'b0);
    tick();

    // Reset mid-multiply aborts with no result
    send(4'd13, 32'd7, 32'd6);
    for (int k = 0; k < 10; k++) tick();
    check("mid-mul busy", 64'({bus.busy, bus.out_valid}), 64'b10);
    rst_n = 1'b0;
    tick();
    check("mul abort vld/busy/res", 64'({bus.out_valid, bus.busy, bus.result}), 64'd0);
    rst_n = 1'b1;
    #1;
    check("mul abort in_ready", 64'(bus.in_ready), 64'd1);
    nv = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.out_valid) nv++;
    end
    check("no stale mul result", 64'(nv), 64'd0);
`else
    send(4'd13, 32'd7, 32'd6);
    check("op13 reserved vld/res/c/v/z",
          64'({bus.out_valid, bus.result, bus.carryout, bus.overflow, bus.zero}),
          64'({1'b1, 32'hFFFFFFFF, 3'b000}));
    check("op13 busy", 64'(bus.busy), 64'd0);
    tick();
    check("op13 drained", 64'(bus.out_valid), 64'd0);
    nv = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
